rerequest_ctrl: RTL and testbench
=================================

// Module: rerequest_ctrl
// PURPOSE
//  MoldUDP64 receive-side gap/retransmission controller. Tracks the next expected
//  sequence number from accepted packet headers. On a gap it issues a retransmission
//  request, arms a response timeout and retries up to a bounded count. Also supervises
//  session liveness (heartbeat timeout) and end-of-session. Sits after header decode;
//  drives the request-packet builder.
// PARAMETERS
//  SEQ_W      64     sequence number width
//  CNT_W      16     message count width
//  TO_W       14     timeout counter width
//  RETRY_CNT  10000  cycles to wait for a retransmission before re-requesting
//  HB_CNT     10000  cycles without any packet before session_lost_o asserts
//  MAX_RETRY  3      requests per gap before giving up (FAIL)
//  MAX_REQ    16'hFFFE  largest message count put in one request
// PORTS
//  clk            in   1      clock
//  reset          in   1      synchronous reset, active-high
//  pkt_v_i        in   1      valid header this cycle
//  pkt_seq_i      in   SEQ_W  header sequence number (first message)
//  pkt_cnt_i      in   CNT_W  header message count (0 = heartbeat, FFFF = end of session)
//  req_v_o        out  1      retransmission request valid
//  req_ready_i    in   1      request builder accepts req this cycle
//  req_seq_o      out  SEQ_W  first missing sequence number
//  req_cnt_o      out  CNT_W  number of missing messages requested
//  gap_o          out  1      gap outstanding (state REQ or WAIT)
//  fail_o         out  1      retries exhausted, sticky until reset
//  eos_o          out  1      end of session seen, sticky until reset
//  session_lost_o out  1      no packet for HB_CNT cycles
// BEHAVIOUR
//  Reset: exp_q=1, top_q=1, state IDLE, retry=0, timers loaded; all outputs 0.
//  Header processing (pkt_v_i=1), end = pkt_seq_i+pkt_cnt_i (mod 2^SEQ_W, unsigned cmp):
//   - cnt==FFFF: eos_o<=1, state->IDLE, req_v_o drops; later headers ignored except liveness.
//   - cnt==0 (heartbeat): liveness reload only; if seq>exp_q treat as gap (top_q<=max(top_q,seq)).
//   - seq<=exp_q<end: exp_q<=end (advance). seq>exp_q: top_q<=max(top_q,seq), exp_q kept.
//   - end<=exp_q: duplicate, ignored.
//  gap exists iff top_q>exp_q. req_seq_o=exp_q; req_cnt_o=min(top_q-exp_q,MAX_REQ).
//  FSM:
//   IDLE: gap & ~eos -> REQ, retry<=0.
//   REQ : req_v_o=1; req_seq_o/req_cnt_o frozen while req_v_o&~req_ready_i.
//         req_ready_i -> WAIT, load timeout RETRY_CNT, retry<=retry+1.
//   WAIT: exp_q advanced & no gap -> IDLE. exp_q advanced & gap -> REQ, retry<=0.
//         timeout zero & retry<MAX_RETRY -> REQ. timeout zero & retry==MAX_RETRY -> FAIL.
//   FAIL: fail_o=1, req_v_o=0; only reset leaves FAIL (eos_o still tracked).
//  Timeout counter: decrements in WAIT, saturates at 0; zero seen the cycle after it reaches 0.
//  Liveness counter: reloads HB_CNT on any pkt_v_i, decrements otherwise, saturates at 0;
//   session_lost_o = (counter==0), clears the cycle after next pkt_v_i.
//  Simultaneous: pkt_v_i advancing exp_q beats timeout expiry in same cycle; eos beats all.
//  Request latency: gap header at cycle t -> req_v_o=1 at t+2 (top_q reg, then FSM).
//  Reset mid-request drops req_v_o next cycle regardless of req_ready_i.
// TESTING
//  1 hdr(seq=1,cnt=5) then hdr(seq=6,cnt=2) -> exp_q=8, gap_o=0, no req_v_o.
//  2 exp=8, hdr(seq=20,cnt=3) -> req_v_o at +2 cycles, req_seq_o=8, req_cnt_o=12; hold
//    req_ready_i=0 10 cycles -> payload stable; ready -> WAIT.
//  3 case 2, no fill, RETRY_CNT=8, MAX_RETRY=3 -> 3 requests ~9 cycles apart, then fail_o=1.
//  4 in WAIT, hdr(seq=8,cnt=12) -> exp_q=20, state IDLE, gap_o=0 next cycle.
//  5 hdr(seq=x,cnt=FFFF) while in REQ -> eos_o=1, req_v_o=0 next cycle.
//  6 HB_CNT=16, no pkt 16 cycles -> session_lost_o=1; heartbeat (cnt=0) -> clears.

Source files
------------

// File: rtl/rerequest_ctrl.sv
// rtl/rerequest_ctrl.sv - MoldUDP64 receive-side gap detection and retransmission request controller
module rerequest_ctrl #(
    parameter int SEQ_W     = 64,
    parameter int CNT_W     = 16,
    parameter int TO_W      = 14,
    parameter int RETRY_CNT = 10000,
    parameter int HB_CNT    = 10000,
    parameter int MAX_RETRY = 3,
    parameter logic [CNT_W-1:0] MAX_REQ = 16'hFFFE
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pkt_v_i,
    input  logic [SEQ_W-1:0] pkt_seq_i,
    input  logic [CNT_W-1:0] pkt_cnt_i,
    output logic             req_v_o,
    input  logic             req_ready_i,
    output logic [SEQ_W-1:0] req_seq_o,
    output logic [CNT_W-1:0] req_cnt_o,
    output logic             gap_o,
    output logic             fail_o,
    output logic             eos_o,
    output logic             session_lost_o
);

    localparam int RTY_W = (MAX_RETRY < 2) ? 1 : $clog2(MAX_RETRY + 1);
    localparam logic [RTY_W-1:0] MAX_RTY   = RTY_W'(MAX_RETRY);
    localparam logic [TO_W-1:0]  TO_LOAD   = TO_W'(RETRY_CNT);
    localparam logic [TO_W-1:0]  HB_LOAD   = TO_W'(HB_CNT);
    localparam logic [CNT_W-1:0] CNT_EOS   = '1;
    localparam logic [SEQ_W-1:0] MAX_REQ_W = {{(SEQ_W-CNT_W){1'b0}}, MAX_REQ};

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_FAIL
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [SEQ_W-1:0] r_exp;
    logic [SEQ_W-1:0] r_top;
    logic [SEQ_W-1:0] r_req_seq;
    logic [CNT_W-1:0] r_req_cnt;
    logic [RTY_W-1:0] r_retry;
    logic [RTY_W-1:0] w_retry_nxt;
    logic [TO_W-1:0]  r_to;
    logic [TO_W-1:0]  w_to_nxt;
    logic [TO_W-1:0]  r_hb;
    logic             r_eos;

    logic [SEQ_W-1:0] w_end;
    logic             w_hdr;
    logic             w_is_eos;
    logic             w_data;
    logic             w_adv;
    logic             w_ahead;
    logic [SEQ_W-1:0] w_exp_nxt;
    logic [SEQ_W-1:0] w_top_nxt;
    logic [SEQ_W-1:0] w_diff;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_gap;
    logic             w_gap_nxt;
    logic             w_load;

    // Once end of session is seen, headers only feed the liveness counter.
    assign w_hdr     = pkt_v_i & ~r_eos;
    assign w_is_eos  = w_hdr & (pkt_cnt_i == CNT_EOS);
    assign w_data    = w_hdr & ~w_is_eos;
    assign w_end     = pkt_seq_i + {{(SEQ_W-CNT_W){1'b0}}, pkt_cnt_i};
    assign w_adv     = w_data & (pkt_seq_i <= r_exp) & (r_exp < w_end);
    assign w_ahead   = w_data & (pkt_seq_i > r_exp);
    assign w_exp_nxt = w_adv ? w_end : r_exp;
    assign w_top_nxt = (w_ahead && (pkt_seq_i > r_top)) ? pkt_seq_i : r_top;
    assign w_gap     = r_top > r_exp;
    assign w_gap_nxt = w_top_nxt > w_exp_nxt;
    assign w_diff    = w_top_nxt - w_exp_nxt;
    assign w_cnt_nxt = !w_gap_nxt           ? '0 :
                       (w_diff > MAX_REQ_W) ? MAX_REQ :
                                              w_diff[CNT_W-1:0];

    // Request payload is captured on entry to REQ so it stays stable until accepted.
    assign w_load = (w_state_nxt == S_REQ) && (r_state != S_REQ);

    // Next-state, retry and timeout decisions; eos overrides everything except FAIL.
    always_comb begin
        w_state_nxt = r_state;
        w_retry_nxt = r_retry;
        w_to_nxt    = ((r_state == S_WAIT) && (r_to != '0)) ? r_to - 1'b1 : r_to;
        case (r_state)
            S_IDLE: begin
                if (w_gap && !r_eos) begin
                    w_state_nxt = S_REQ;
                    w_retry_nxt = '0;
                end
            end
            S_REQ: begin
                if (req_ready_i) begin
                    w_state_nxt = S_WAIT;
                    w_to_nxt    = TO_LOAD;
                    w_retry_nxt = r_retry + 1'b1;
                end
            end
            S_WAIT: begin
                if (w_adv) begin
                    if (w_gap_nxt) begin
                        w_state_nxt = S_REQ;
                        w_retry_nxt = '0;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end else if (r_to == '0) begin
                    w_state_nxt = (r_retry < MAX_RTY) ? S_REQ : S_FAIL;
                end
            end
            default: begin
                w_state_nxt = S_FAIL;
            end
        endcase
        if (w_is_eos && (r_state != S_FAIL)) begin
            w_state_nxt = S_IDLE;
        end
    end

    // FSM, sequence tracking and request payload registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_exp     <= SEQ_W'(1);
            r_top     <= SEQ_W'(1);
            r_retry   <= '0;
            r_to      <= TO_LOAD;
            r_eos     <= 1'b0;
            r_req_seq <= '0;
            r_req_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_exp   <= w_exp_nxt;
            r_top   <= w_top_nxt;
            r_retry <= w_retry_nxt;
            r_to    <= w_to_nxt;
            if (w_is_eos) begin
                r_eos <= 1'b1;
            end
            if (w_load) begin
                r_req_seq <= w_exp_nxt;
                r_req_cnt <= w_cnt_nxt;
            end
        end
    end

    // Liveness counter: any header reloads it, otherwise it runs down to zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_hb <= HB_LOAD;
        end else if (pkt_v_i) begin
            r_hb <= HB_LOAD;
        end else if (r_hb != '0) begin
            r_hb <= r_hb - 1'b1;
        end
    end

    assign req_v_o        = (r_state == S_REQ);
    assign req_seq_o      = r_req_seq;
    assign req_cnt_o      = r_req_cnt;
    assign gap_o          = (r_state == S_REQ) || (r_state == S_WAIT);
    assign fail_o         = (r_state == S_FAIL);
    assign eos_o          = r_eos;
    assign session_lost_o = (r_hb == '0);

endmodule

// File: tb/tb_rerequest_ctrl.sv
// tb/tb_rerequest_ctrl.sv - randomized and directed checks of rerequest_ctrl against a reference model
module tb_rerequest_ctrl;

    localparam int RETRY_CNT = 8;
    localparam int HB_CNT    = 16;
    localparam int MAX_RETRY = 3;
    localparam int MAX_REQ   = 20;

    logic        clk;
    logic        reset;
    logic        pkt_v_i;
    logic [63:0] pkt_seq_i;
    logic [15:0] pkt_cnt_i;
    logic        req_v_o;
    logic        req_ready_i;
    logic [63:0] req_seq_o;
    logic [15:0] req_cnt_o;
    logic        gap_o;
    logic        fail_o;
    logic        eos_o;
    logic        session_lost_o;

    rerequest_ctrl #(
        .SEQ_W(64), .CNT_W(16), .TO_W(14), .RETRY_CNT(RETRY_CNT), .HB_CNT(HB_CNT),
        .MAX_RETRY(MAX_RETRY), .MAX_REQ(16'd20)
    ) dut (
        .clk(clk), .reset(reset), .pkt_v_i(pkt_v_i), .pkt_seq_i(pkt_seq_i),
        .pkt_cnt_i(pkt_cnt_i), .req_v_o(req_v_o), .req_ready_i(req_ready_i),
        .req_seq_o(req_seq_o), .req_cnt_o(req_cnt_o), .gap_o(gap_o), .fail_o(fail_o),
        .eos_o(eos_o), .session_lost_o(session_lost_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input longint unsigned obs, input longint unsigned exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: phases 0 idle, 1 requesting, 2 waiting for refill, 3 failed.
    longint unsigned m_exp, m_top, m_pay_seq;
    int  m_phase, m_retry, m_wait_age, m_since_pkt, m_pay_cnt;
    bit  m_eos;

    task automatic model_step(input bit v, input longint unsigned seq, input int cnt,
                              input bit rdy, input bit rst);
        longint unsigned fin, n_exp, n_top;
        bit hdr, is_eos, adv, gap_old;
        int n_phase;
        if (rst) begin
            m_exp = 1; m_top = 1; m_phase = 0; m_retry = 0; m_wait_age = 0;
            m_since_pkt = 0; m_eos = 0; m_pay_seq = 0; m_pay_cnt = 0;
            return;
        end
        gap_old = m_top > m_exp;
        hdr     = v && !m_eos;
        is_eos  = hdr && (cnt == 16'hFFFF);
        fin     = seq + longint'(cnt);
        adv     = hdr && !is_eos && (seq <= m_exp) && (m_exp < fin);
        n_exp   = adv ? fin : m_exp;
        n_top   = m_top;
        if (hdr && !is_eos && seq > m_exp && seq > m_top) n_top = seq;
        m_since_pkt = v ? 0 : ((m_since_pkt < 1000) ? m_since_pkt + 1 : m_since_pkt);
        n_phase = m_phase;
        case (m_phase)
            0: if (gap_old && !m_eos) begin n_phase = 1; m_retry = 0; end
            1: if (rdy) begin n_phase = 2; m_retry++; m_wait_age = 1; end
            2: begin
                if (adv) begin
                    n_phase = (n_top > n_exp) ? 1 : 0;
                    if (n_phase == 1) m_retry = 0;
                end else if (m_wait_age == RETRY_CNT + 1) begin
                    n_phase = (m_retry < MAX_RETRY) ? 1 : 3;
                end else begin
                    m_wait_age++;
                end
            end
            default: n_phase = 3;
        endcase
        if (is_eos) begin
            m_eos = 1;
            if (m_phase != 3) n_phase = 0;
        end
        if (n_phase == 1 && m_phase != 1) begin
            m_pay_seq = n_exp;
            m_pay_cnt = (n_top > n_exp) ? ((n_top - n_exp > MAX_REQ) ? MAX_REQ : int'(n_top - n_exp)) : 0;
        end
        m_exp = n_exp; m_top = n_top; m_phase = n_phase;
    endtask

    task automatic check_outputs();
        check_eq("req_v", req_v_o, m_phase == 1);
        check_eq("gap", gap_o, (m_phase == 1) || (m_phase == 2));
        check_eq("fail", fail_o, m_phase == 3);
        check_eq("eos", eos_o, m_eos);
        check_eq("lost", session_lost_o, m_since_pkt >= HB_CNT);
        if (m_phase == 1) begin
            check_eq("req_seq", req_seq_o, m_pay_seq);
            check_eq("req_cnt", req_cnt_o, m_pay_cnt);
        end
    endtask

    task automatic cyc(input bit v, input longint unsigned seq, input logic [15:0] cnt,
                       input bit rdy, input bit rst);
        reset = rst; pkt_v_i = v; pkt_seq_i = seq; pkt_cnt_i = cnt; req_ready_i = rdy;
        model_step(v, seq, int'(cnt), rdy, rst);
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic do_reset();
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 1);
    endtask

    initial begin
        int hs[$];
        longint unsigned seq;
        int cnt, kind, seg;
        bit v, rst;

        do_reset();
        check_eq("rst_req_v", req_v_o, 0);
        check_eq("rst_gap", gap_o, 0);
        check_eq("rst_lost", session_lost_o, 0);

        // In-order headers advance without a gap; then a gap is requested.
        cyc(1, 1, 5, 0, 0);
        cyc(1, 6, 2, 0, 0);
        cyc(0, 0, 0, 0, 0);
        check_eq("t1_gap", gap_o, 0);
        check_eq("t1_req_v", req_v_o, 0);
        cyc(1, 20, 3, 0, 0);
        check_eq("t2_req_v_t1", req_v_o, 0);
        cyc(0, 0, 0, 0, 0);
        check_eq("t2_req_v_t2", req_v_o, 1);
        check_eq("t2_req_seq", req_seq_o, 8);
        check_eq("t2_req_cnt", req_cnt_o, 12);
        for (int i = 0; i < 10; i++) begin
            cyc(0, 0, 0, 0, 0);
            check_eq("t2_hold_seq", req_seq_o, 8);
            check_eq("t2_hold_cnt", req_cnt_o, 12);
        end
        cyc(0, 0, 0, 1, 0);
        check_eq("t2_wait_gap", gap_o, 1);
        check_eq("t2_wait_req_v", req_v_o, 0);
        cyc(1, 8, 12, 0, 0);
        check_eq("t4_gap", gap_o, 0);
        check_eq("t4_req_v", req_v_o, 0);

        // Unfilled gap: three requests spaced by the timeout, then FAIL.
        do_reset();
        cyc(1, 1, 7, 1, 0);
        cyc(1, 20, 3, 1, 0);
        for (int i = 0; i < 60 && !fail_o; i++) begin
            if (req_v_o) hs.push_back(i);
            cyc(0, 0, 0, 1, 0);
        end
        check_eq("t3_requests", hs.size(), 3);
        if (hs.size() >= 3) begin
            check_eq("t3_space0", hs[1] - hs[0], RETRY_CNT + 2);
            check_eq("t3_space1", hs[2] - hs[1], RETRY_CNT + 2);
        end
        check_eq("t3_fail", fail_o, 1);
        cyc(1, 8, 12, 1, 0);
        cyc(0, 0, 0, 1, 0);
        check_eq("t3_fail_sticky", fail_o, 1);

        // End of session while requesting.
        do_reset();
        cyc(1, 1, 7, 0, 0);
        cyc(1, 20, 3, 0, 0);
        cyc(0, 0, 0, 0, 0);
        check_eq("t5_in_req", req_v_o, 1);
        cyc(1, 99, 16'hFFFF, 0, 0);
        check_eq("t5_req_v", req_v_o, 0);
        check_eq("t5_eos", eos_o, 1);
        cyc(1, 50, 1, 0, 0);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        check_eq("t5_ignored", req_v_o, 0);

        // Liveness timeout and recovery on a heartbeat.
        do_reset();
        for (int i = 1; i <= HB_CNT; i++) begin
            cyc(0, 0, 0, 0, 0);
            if (i == HB_CNT - 1) check_eq("t6_lost_early", session_lost_o, 0);
        end
        check_eq("t6_lost", session_lost_o, 1);
        cyc(1, 1, 0, 0, 0);
        check_eq("t6_clear", session_lost_o, 0);

        // Randomized traffic, alternating busy and quiet segments.
        do_reset();
        for (int k = 0; k < 6000; k++) begin
            seg = (k / 200) % 2;
            rst = ($urandom_range(0, 299) == 0);
            v   = !rst && ($urandom_range(0, 99) < (seg ? 5 : 40));
            kind = $urandom_range(0, 99);
            seq = m_exp;
            cnt = 1;
            if (kind < 25) begin
                cnt = $urandom_range(1, 4);
            end else if (kind < 45) begin
                seq = m_exp + longint'($urandom_range(1, 40));
                cnt = $urandom_range(0, 3);
            end else if (kind < 65) begin
                cnt = (m_top > m_exp) ? int'(m_top - m_exp) + $urandom_range(0, 2) : $urandom_range(1, 3);
            end else if (kind < 78) begin
                seq = m_exp - longint'((m_exp > 3) ? $urandom_range(0, 3) : 0);
                cnt = $urandom_range(1, 6);
            end else if (kind < 88) begin
                seq = (m_exp > 3) ? m_exp - 3 : 1;
                cnt = $urandom_range(1, 2);
            end else if (kind < 99) begin
                seq = m_exp + longint'($urandom_range(0, 2));
                cnt = 0;
            end else begin
                cnt = 16'hFFFF;
            end
            cyc(v, seq, 16'(cnt), 1'($urandom_range(0, 1)), rst);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
